// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode map, default width, request layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_TAG_W  = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Request layout at the default widths; parameterised users declare a
    // matching local struct with the same field order.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic [1:0]            opcode;
        logic [DEF_TAG_W-1:0]  tag;
    } alu_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: a pushed entry is visible on rdata the edge after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk/reset, push/wdata in, pop in, rdata (head, combinational), full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests and issues one per cycle to a stall-free pipelined ALU, tagging results.
// Latency: accept -> alu_* 1 edge (min); alu_* -> res_valid ALU_LATENCY edges.
// Backpressure: in_ready drops only when the FIFO is full; result side has none.
// Ports: clk/reset; in_valid/in_ready/in_a/in_b/in_opcode request side;
//        alu_a/alu_b/alu_opcode to ALU, alu_result from ALU;
//        res_valid/res_data/res_tag result stream; inflight, empty status.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 2,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_a,
    input  logic [DATA_W-1:0]                  in_b,
    input  logic [1:0]                         in_opcode,
    output logic [DATA_W-1:0]                  alu_a,
    output logic [DATA_W-1:0]                  alu_b,
    output logic [1:0]                         alu_opcode,
    input  logic [DATA_W-1:0]                  alu_result,
    output logic                               res_valid,
    output logic [DATA_W-1:0]                  res_data,
    output logic [TAG_W-1:0]                   res_tag,
    output logic [$clog2(ALU_LATENCY+1)-1:0]   inflight,
    output logic                               empty
);

    localparam int INF_W = $clog2(ALU_LATENCY + 1);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        opcode;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } slot_t;

    req_t                  wr_req;
    req_t                  head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  accept;
    logic                  issue;
    logic [TAG_W-1:0]      tag_ctr;

    // issue_q travels alongside alu_* (the op the ALU is sampling now);
    // line_q[i] is the op whose result is i+1 edges further down the ALU.
    slot_t                 issue_q;
    slot_t                 line_q [ALU_LATENCY];

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign issue    = !fifo_empty;
    assign empty    = fifo_empty;

    assign wr_req = '{a: in_a, b: in_b, opcode: in_opcode, tag: tag_ctr};

    sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (wr_req),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_ctr    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            issue_q    <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                tag_ctr <= tag_ctr + TAG_W'(1);
            end
            // On a bubble alu_* and the slot tag hold; the cleared valid bit
            // is what keeps the stale ALU output from being reported.
            issue_q.vld <= issue;
            if (issue) begin
                alu_a       <= head.a;
                alu_b       <= head.b;
                alu_opcode  <= head.opcode;
                issue_q.tag <= head.tag;
            end
            line_q[0] <= issue_q;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign res_valid = line_q[ALU_LATENCY-1].vld;
    assign res_tag   = line_q[ALU_LATENCY-1].tag;
    assign res_data  = alu_result;

    // Ops issued whose result is not yet on the output: the slot at alu_*
    // plus every line stage ahead of the output stage.
    always_comb begin
        inflight = INF_W'(issue_q.vld);
        for (int i = 0; i < ALU_LATENCY - 1; i++) begin
            inflight = inflight + INF_W'(line_q[i].vld);
        end
    end

    // fifo_count is kept for debug visibility; occupancy decisions use full/empty.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LAT    = 2;
    localparam int TAG_W  = 4;
    localparam int INF_W  = $clog2(LAT + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a, in_b;
    logic [1:0]        in_opcode;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [1:0]        alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic [INF_W-1:0]  inflight;
    logic              empty;

    alu_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ALU_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .inflight(inflight), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_alu(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b, logic [1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    // ALU stub: LAT register stages from alu_* sampling to alu_result.
    logic [DATA_W-1:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= ref_alu(alu_a, alu_b, alu_opcode);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[LAT-1];

    // Reference model: each accepted op issues at the first edge after its
    // accept edge at which the previous op has already issued; its result
    // is reported LAT edges after issue.
    typedef struct {
        logic [DATA_W-1:0] a, b, data;
        logic [1:0]        op;
        logic [TAG_W-1:0]  tag;
        int                acc, iss, res;
    } exp_t;

    exp_t             sb[$];
    int               cyc = 0;
    int               last_iss = -10;
    logic [TAG_W-1:0] m_tag = '0;
    int               checks = 0;
    int               failures = 0;
    bit               mon_en = 0;
    int               m_queued, m_infl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares status every cycle and pops the scoreboard when a
    // result is due.
    always @(negedge clk) begin
        if (mon_en) begin
            m_queued = 0;
            m_infl   = 0;
            foreach (sb[i]) begin
                if (sb[i].acc <= cyc && sb[i].iss > cyc) m_queued++;
                if (sb[i].iss <= cyc && sb[i].res > cyc) m_infl++;
                if (sb[i].iss == cyc) begin
                    chk("alu_a", alu_a, sb[i].a);
                    chk("alu_b", alu_b, sb[i].b);
                    chk("alu_opcode", alu_opcode, sb[i].op);
                end
            end
            chk("in_ready", in_ready, m_queued != DEPTH);
            chk("empty", empty, m_queued == 0);
            chk("inflight", inflight, m_infl);
            if (sb.size() > 0 && sb[0].res == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("res_valid", res_valid, 1);
                chk("res_data", res_data, e.data);
                chk("res_tag", res_tag, e.tag);
            end else begin
                chk("res_valid_idle", res_valid, 0);
            end
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [1:0] op, output bit accepted);
        int queued;
        exp_t e;
        @(negedge clk); #1;
        in_valid = v; in_a = a; in_b = b; in_opcode = op;
        accepted = 0;
        if (v) begin
            queued = 0;
            foreach (sb[i]) if (sb[i].acc <= cyc && sb[i].iss > cyc) queued++;
            if (queued < DEPTH) begin
                accepted = 1;
                e.a = a; e.b = b; e.op = op; e.data = ref_alu(a, b, op); e.tag = m_tag;
                e.acc = cyc + 1;
                e.iss = (e.acc + 1 > last_iss + 1) ? e.acc + 1 : last_iss + 1;
                e.res = e.iss + LAT;
                last_iss = e.iss;
                m_tag = m_tag + 1'b1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [1:0] op);
        bit acc;
        acc = 0;
        for (int t = 0; t < 20 && !acc; t++) drive(1'b1, a, b, op, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, acc);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        sb.delete(); last_iss = -10; m_tag = '0;
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0;
        repeat (2) @(posedge clk);
        mon_en = 1;
        @(negedge clk); #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_res_tag", res_tag, 0);
        reset = 1'b0;

        // Single op, then back-to-back ops.
        send(8'd10, 8'd5, OP_ADD);
        idle(5);
        send(8'd20, 8'd8, OP_SUB);
        send(8'd6, 8'd3, OP_AND);
        send(8'd4, 8'd1, OP_OR);
        idle(5);

        // Isolated requests with 3-cycle gaps.
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom), 8'($urandom), 2'($urandom));
            idle(3);
        end

        // Sustained traffic then random gaps; tags wrap past 15 here.
        for (int i = 0; i < 12; i++) send(8'($urandom), 8'($urandom), 2'($urandom));
        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), 8'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);

        // Reset with two ops in flight, timed to land on the first result edge.
        send(8'd1, 8'd2, OP_ADD);
        send(8'd9, 8'd4, OP_SUB);
        for (int t = 0; t < 20 && sb.size() > 0 && cyc < sb[0].res - 1; t++) idle(1);
        apply_reset(2);
        idle(3);
        send(8'd7, 8'd7, OP_ADD);

        // Drain.
        for (int t = 0; t < 30 && sb.size() > 0; t++) idle(1);
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
